fdiv_dispatch_ctrl: RTL and testbench

FDIV_DISPATCH_CTRL -- requirements
Module: fdiv_dispatch_ctrl

---
 rtl/fpu_pkg.sv | 32 +++
 rtl/fdiv_req_fifo.sv | 47 ++++
 rtl/fdiv_dispatch_ctrl.sv | 142 ++++++++++++++
 tb/tb_fdiv_dispatch_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP divide dispatch slice: FSM states, fflag bit
// positions and the default ROB tag width.
package fpu_pkg;

    localparam int DEFAULT_TAG_W = 6;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_HOLD
    } div_state_e;

    // The divider never reports invalid; inexact is implied by any range error.
    function automatic logic [4:0] pack_fflags(input logic dz, input logic of, input logic uf);
        logic [4:0] f;
        f        = '0;
        f[FF_NV] = 1'b0;
        f[FF_DZ] = dz;
        f[FF_OF] = of;
        f[FF_UF] = uf;
        f[FF_NX] = of | uf;
        return f;
    endfunction

endpackage

// File: rtl/fdiv_req_fifo.sv
// Synchronous request queue with single-cycle clear; rst_n is active-high here,
// matching the rest of the FP dispatch block.
module fdiv_req_fifo #(
    parameter int WIDTH = 70,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst_n || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/fdiv_dispatch_ctrl.sv
// Dispatches queued FP divide requests to a single iterative divider, one at a
// time, and returns quotients to the CDB in acceptance order.
module fdiv_dispatch_ctrl
    import fpu_pkg::*;
#(
    parameter int TAG_W  = DEFAULT_TAG_W,
    parameter int QDEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             div_start,
    output logic [31:0]      div_a,
    output logic [31:0]      div_b,
    input  logic             div_done,
    input  logic [31:0]      div_result,
    input  logic             div_zero_division,
    input  logic             div_overflow,
    input  logic             div_underflow,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic [31:0]      wb_result,
    output logic [4:0]       wb_fflags,
    output logic             busy
);

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } req_t;

    req_t push_ent;
    req_t head;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    div_state_e       state_q;
    logic             discard_q;
    logic [31:0]      div_a_q;
    logic [31:0]      div_b_q;
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] wb_tag_q;
    logic [31:0]      wb_result_q;
    logic [4:0]       wb_fflags_q;

    // No bypass: a full queue refuses new work even while it is being popped.
    assign req_ready = !rst_n && !flush && !fifo_full;
    assign push      = req_valid && req_ready;
    assign push_ent  = '{a: req_a, b: req_b, tag: req_tag};
    assign pop       = !rst_n && !flush && !fifo_empty &&
                       ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && wb_ready));

    fdiv_req_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (QDEPTH)
    ) u_req_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (flush),
        .push_i      (push),
        .push_data_i (push_ent),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // A flush arriving in LAUNCH cancels the start pulse of that same cycle.
    assign div_start = !rst_n && !flush && (state_q == ST_LAUNCH);
    assign wb_valid  = !rst_n && (state_q == ST_HOLD);
    assign busy      = !rst_n && ((state_q != ST_IDLE) || !fifo_empty);
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign wb_tag    = wb_tag_q;
    assign wb_result = wb_result_q;
    assign wb_fflags = wb_fflags_q;

    // NOTE: every register in this block is state, so all updates use <= to
    // read the pre-edge values consistently regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= ST_IDLE;
            discard_q   <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            tag_q       <= '0;
            wb_tag_q    <= '0;
            wb_result_q <= '0;
            wb_fflags_q <= '0;
        end else begin
            if (pop) begin
                div_a_q <= head.a;
                div_b_q <= head.b;
                tag_q   <= head.tag;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (pop) state_q <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    state_q <= flush ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    // A killed division must still drain so the divider is free.
                    if (div_done) begin
                        if (discard_q || flush) begin
                            discard_q <= 1'b0;
                            state_q   <= ST_IDLE;
                        end else begin
                            wb_tag_q    <= tag_q;
                            wb_result_q <= div_result;
                            wb_fflags_q <= pack_fflags(div_zero_division, div_overflow,
                                                       div_underflow);
                            state_q     <= ST_HOLD;
                        end
                    end else if (flush) begin
                        discard_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else if (wb_ready) begin
                        state_q <= pop ? ST_LAUNCH : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_dispatch_ctrl.sv
// Self-checking bench for fdiv_dispatch_ctrl: a queue-based reference model
// compared every cycle, directed scenarios with literal results, then random traffic.
module tb_fdiv_dispatch_ctrl;

    localparam int TAG_W  = 6;
    localparam int QDEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic             div_start;
    logic [31:0]      div_a;
    logic [31:0]      div_b;
    logic             div_done;
    logic [31:0]      div_result;
    logic             div_zero_division;
    logic             div_overflow;
    logic             div_underflow;
    logic             wb_valid;
    logic             wb_ready;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_result;
    logic [4:0]       wb_fflags;
    logic             busy;

    always #5 clk = ~clk;

    fdiv_dispatch_ctrl #(.TAG_W(TAG_W), .QDEPTH(QDEPTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_a             (req_a),
        .req_b             (req_b),
        .req_tag           (req_tag),
        .div_start         (div_start),
        .div_a             (div_a),
        .div_b             (div_b),
        .div_done          (div_done),
        .div_result        (div_result),
        .div_zero_division (div_zero_division),
        .div_overflow      (div_overflow),
        .div_underflow     (div_underflow),
        .wb_valid          (wb_valid),
        .wb_ready          (wb_ready),
        .wb_tag            (wb_tag),
        .wb_result         (wb_result),
        .wb_fflags         (wb_fflags),
        .busy              (busy)
    );

    typedef struct packed {
        logic [31:0] q;
        logic        dz;
        logic        of;
        logic        uf;
    } dres_t;

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } job_t;

    // What the divider stub returns for a given operand pair.
    function automatic dres_t ref_div(input logic [31:0] a, input logic [31:0] b);
        dres_t r;
        r = '0;
        if (b == 32'h0) begin
            r.q  = 32'h7F80_0000;
            r.dz = 1'b1;
        end else if (a == 32'h4120_0000 && b == 32'h4000_0000) begin
            r.q = 32'h40A0_0000;
        end else begin
            r.q  = a ^ {b[15:0], b[31:16]};
            r.of = a[0] & b[0];
            r.uf = a[1] ^ b[2];
        end
        return r;
    endfunction

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Divider stub: done rises stub_lat cycles after a start, stays up 1-3 cycles.
    int    stub_lat  = 3;
    bit    stub_rand = 1'b0;
    bit    armed     = 1'b0;
    int    done_at   = 0;
    int    done_len  = 1;
    dres_t stub_r    = '0;

    initial begin
        div_done          = 1'b0;
        div_result        = '0;
        div_zero_division = 1'b0;
        div_overflow      = 1'b0;
        div_underflow     = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div_done          = armed && (cyc >= done_at) && (cyc < done_at + done_len);
            div_result        = stub_r.q;
            div_zero_division = stub_r.dz;
            div_overflow      = stub_r.of;
            div_underflow     = stub_r.uf;
            #3;
            if (div_start === 1'b1) begin
                armed    = 1'b1;
                done_at  = cyc + (stub_rand ? int'($urandom_range(1, 5)) : stub_lat);
                done_len = int'($urandom_range(1, 3));
                stub_r   = ref_div(div_a, div_b);
            end
        end
    end

    // Reference model: pending queue plus the stage of the one active job.
    job_t             pend[$];
    job_t             cur;
    bit               m_launch, m_wait, m_hold, m_discard;
    logic [31:0]      e_a, e_b, e_res;
    logic [TAG_W-1:0] e_tag;
    logic [4:0]       e_ff;
    int               start_cnt      = 0;
    int               last_start_cyc = -1;
    int               wbv_cnt        = 0;
    int               wb_log[$];

    initial begin : compare
        bit    e_ready, e_start, e_wbv, e_busy, idle, popq, accept;
        dres_t d;
        m_launch = 0; m_wait = 0; m_hold = 0; m_discard = 0;
        e_a = '0; e_b = '0; e_res = '0; e_tag = '0; e_ff = '0;
        cur = '0;
        forever begin
            @(negedge clk);
            e_ready = !rst_n && !flush && (pend.size() < QDEPTH);
            e_start = !rst_n && !flush && m_launch;
            e_wbv   = !rst_n && m_hold;
            e_busy  = !rst_n && (m_launch || m_wait || m_hold || pend.size() > 0);
            check("req_ready", 32'(req_ready), 32'(e_ready));
            check("div_start", 32'(div_start), 32'(e_start));
            check("wb_valid",  32'(wb_valid),  32'(e_wbv));
            check("busy",      32'(busy),      32'(e_busy));
            check("div_a",     div_a,          e_a);
            check("div_b",     div_b,          e_b);
            check("wb_tag",    32'(wb_tag),    32'(e_tag));
            check("wb_result", wb_result,      e_res);
            check("wb_fflags", 32'(wb_fflags), 32'(e_ff));

            if (div_start) begin
                start_cnt++;
                last_start_cyc = cyc;
            end
            if (wb_valid) wbv_cnt++;
            if (wb_valid && wb_ready && !flush && !rst_n) wb_log.push_back(int'(wb_tag));

            if (rst_n) begin
                pend.delete();
                m_launch = 0; m_wait = 0; m_hold = 0; m_discard = 0;
                e_a = '0; e_b = '0; e_res = '0; e_tag = '0; e_ff = '0;
            end else begin
                idle   = !(m_launch || m_wait || m_hold);
                popq   = !flush && pend.size() > 0 && (idle || (m_hold && wb_ready));
                accept = e_ready && req_valid;
                if (m_launch) begin
                    m_launch = 0;
                    m_wait   = !flush;
                end else if (m_wait) begin
                    if (div_done) begin
                        m_wait = 0;
                        if (m_discard || flush) begin
                            m_discard = 0;
                        end else begin
                            d      = ref_div(cur.a, cur.b);
                            e_res  = d.q;
                            e_tag  = cur.tag;
                            e_ff   = {1'b0, d.dz, d.of, d.uf, d.of | d.uf};
                            m_hold = 1;
                        end
                    end else if (flush) begin
                        m_discard = 1;
                    end
                end else if (m_hold && (flush || wb_ready)) begin
                    m_hold = 0;
                end
                if (popq) begin
                    cur      = pend.pop_front();
                    e_a      = cur.a;
                    e_b      = cur.b;
                    m_launch = 1;
                end
                if (flush) pend.delete();
                if (accept) pend.push_back('{a: req_a, b: req_b, tag: req_tag});
            end
        end
    end

    bit saw_block = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds a request until accepted; returns the acceptance cycle.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input int tag, output int acc);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_tag   = TAG_W'(tag);
        acc       = -1;
        for (int i = 0; i < 100 && acc < 0; i++) begin
            #2;
            if (req_ready) acc = cyc;
            else           saw_block = 1'b1;
            step();
        end
        req_valid = 1'b0;
        check("send_accepted", 32'(acc >= 0), 32'd1);
    endtask

    task automatic wait_wb(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #2;
            if (wb_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check({name, "_wb_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_start(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #2;
            if (div_start) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check({name, "_start_seen"}, 32'(ok), 32'd1);
    endtask

    initial begin : stimulus
        int acc;
        int s0, n0, v0, hits;
        rst_n     = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        wb_ready  = 1'b1;
        repeat (3) step();
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_div_start", 32'(div_start), 32'd0);
        check("rst_wb_valid",  32'(wb_valid),  32'd0);
        step();
        rst_n = 1'b0;

        // 10.0 / 2.0 with minimum dispatch latency
        stub_lat = 3;
        send(32'h4120_0000, 32'h4000_0000, 5, acc);
        wait_wb("t1");
        check("t1_start_latency", 32'(last_start_cyc - acc), 32'd2);
        check("t1_wb_result", wb_result, 32'h40A0_0000);
        check("t1_wb_tag",    32'(wb_tag), 32'd5);
        check("t1_wb_fflags", 32'(wb_fflags), 32'h00);
        step();

        // divide by zero
        send(32'h40A0_0000, 32'h0000_0000, 9, acc);
        wait_wb("t2");
        check("t2_wb_result", wb_result, 32'h7F80_0000);
        check("t2_wb_tag",    32'(wb_tag), 32'd9);
        check("t2_wb_fflags", 32'(wb_fflags), 32'h08);
        step();

        // four back-to-back requests overrun the two-entry queue
        stub_lat  = 4;
        s0        = start_cnt;
        n0        = wb_log.size();
        saw_block = 1'b0;
        for (int t = 1; t <= 4; t++) send(32'h4000_0000 + 32'(t), 32'h3F80_0000, t, acc);
        for (int i = 0; i < 200 && wb_log.size() < n0 + 4; i++) step();
        check("t3_wb_count",    32'(wb_log.size() - n0), 32'd4);
        check("t3_start_count", 32'(start_cnt - s0), 32'd4);
        check("t3_ready_drop",  32'(saw_block), 32'd1);
        for (int i = 0; i < 4; i++)
            if (wb_log.size() > n0 + i) check("t3_order", 32'(wb_log[n0 + i]), 32'(i + 1));

        // flush while tag 3 is in the divider and tag 4 is queued
        stub_lat = 8;
        send(32'h3F80_0000, 32'h4000_0000, 3, acc);
        wait_start("t4");
        step();
        send(32'h3F80_0000, 32'h4040_0000, 4, acc);
        flush = 1'b1;
        step();
        flush = 1'b0;
        n0 = wb_log.size();
        send(32'h4120_0000, 32'h4000_0000, 7, acc);
        wait_wb("t4");
        check("t4_wb_tag",    32'(wb_tag), 32'd7);
        check("t4_wb_result", wb_result, 32'h40A0_0000);
        step();
        hits = 0;
        for (int i = n0; i < wb_log.size(); i++)
            if (wb_log[i] == 3 || wb_log[i] == 4) hits++;
        check("t4_flushed_tags_absent", 32'(hits), 32'd0);

        // writeback backpressure with a queued request behind it
        stub_lat = 2;
        wb_ready = 1'b0;
        send(32'h4120_0000, 32'h4000_0000, 11, acc);
        send(32'h3F80_0000, 32'h3F80_0000, 12, acc);
        wait_wb("t5");
        s0 = start_cnt;
        for (int i = 0; i < 10; i++) begin
            check("t5_hold_valid",  32'(wb_valid), 32'd1);
            check("t5_hold_tag",    32'(wb_tag), 32'd11);
            check("t5_hold_result", wb_result, 32'h40A0_0000);
            check("t5_hold_fflags", 32'(wb_fflags), 32'h00);
            step();
            #2;
        end
        check("t5_no_start_in_hold", 32'(start_cnt - s0), 32'd0);
        step();
        wb_ready = 1'b1;
        wait_start("t5");
        step();
        wait_wb("t5b");
        check("t5_second_tag",    32'(wb_tag), 32'd12);
        check("t5_second_result", wb_result, 32'h3F80_3F80);
        step();

        // reset during WAIT; the late div_done must be ignored
        stub_lat = 6;
        send(32'h4120_0000, 32'h4000_0000, 13, acc);
        wait_start("t6");
        step();
        step();
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        #2;
        check("t6_div_a",     div_a, 32'h0);
        check("t6_div_b",     div_b, 32'h0);
        check("t6_wb_tag",    32'(wb_tag), 32'd0);
        check("t6_wb_result", wb_result, 32'h0);
        check("t6_wb_fflags", 32'(wb_fflags), 32'd0);
        check("t6_wb_valid",  32'(wb_valid), 32'd0);
        check("t6_div_start", 32'(div_start), 32'd0);
        check("t6_busy",      32'(busy), 32'd0);
        v0 = wbv_cnt;
        s0 = start_cnt;
        repeat (12) step();
        check("t6_no_wb_after_reset",    32'(wbv_cnt - v0), 32'd0);
        check("t6_no_start_after_reset", 32'(start_cnt - s0), 32'd0);

        // random traffic against the model
        stub_rand = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            rst_n     = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            req_valid = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 5) == 0) begin
                req_a = 32'h4120_0000;
                req_b = 32'h4000_0000;
            end else begin
                req_a = $urandom;
                req_b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            end
            req_tag  = TAG_W'($urandom);
            wb_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        wb_ready  = 1'b1;
        repeat (40) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
